// File: rtl/regfile_sequencer_pkg.sv
// Shared definitions for the TinyRV register-file sequencer.
// Holds the datapath geometry (XLEN, SLICE, REG_AW, NPHASE), the FSM state
// encoding and a helper that picks one slice out of a full-width word.
package regfile_sequencer_pkg;

  localparam int XLEN   = 32;
  localparam int SLICE  = 8;
  localparam int REG_AW = 4;
  localparam int NPHASE = XLEN / SLICE;
  localparam int PH_W   = $clog2(NPHASE);

  localparam logic [PH_W-1:0] PH_ZERO = PH_W'(0);
  localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(NPHASE - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } seq_state_e;

  // Selects slice number ph of a full register word.
  function automatic logic [SLICE-1:0] slice_of(input logic [XLEN-1:0] word,
                                                input logic [PH_W-1:0] ph);
    slice_of = word[ph*SLICE +: SLICE];
  endfunction

endpackage

// File: rtl/regfile_sequencer_if.sv
// Request/response bus between core control and the register-file sequencer.
// master: the requester (drives req_*, rsp_ready).
// slave : the sequencer (drives req_ready, rsp_valid, rsp_rs1_dat, rsp_rs2_dat).
interface regfile_sequencer_if;
  import regfile_sequencer_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [REG_AW-1:0] req_rs1;
  logic [REG_AW-1:0] req_rs2;
  logic [REG_AW-1:0] req_rd;
  logic              req_wr;
  logic [XLEN-1:0]   req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_rs1_dat;
  logic [XLEN-1:0]   rsp_rs2_dat;

  modport master (
    output req_valid, req_rs1, req_rs2, req_rd, req_wr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rs1_dat, rsp_rs2_dat
  );

  modport slave (
    input  req_valid, req_rs1, req_rs2, req_rd, req_wr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rs1_dat, rsp_rs2_dat
  );

endinterface

// File: rtl/regfile_sequencer_capture.sv
// Operand assembly registers for the sequencer.
// Ports: clk, rst_n; load (capture enable, one slice per cycle), phase (slice
// lane to load), rs1_zero/rs2_zero (source is x0), rs1_slice/rs2_slice (read
// slices from the file), rs1_dat/rs2_dat (assembled XLEN-bit operands).
module regfile_sequencer_capture
  import regfile_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [PH_W-1:0]  phase,
  input  logic             rs1_zero,
  input  logic             rs2_zero,
  input  logic [SLICE-1:0] rs1_slice,
  input  logic [SLICE-1:0] rs2_slice,
  output logic [XLEN-1:0]  rs1_dat,
  output logic [XLEN-1:0]  rs2_dat
);

  logic [XLEN-1:0] rs1_r;
  logic [XLEN-1:0] rs2_r;

  // Byte-lane load of both operands; x0 lanes are forced to zero whatever the file returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_r <= {XLEN{1'b0}};
      rs2_r <= {XLEN{1'b0}};
    end else if (load) begin
      rs1_r[phase*SLICE +: SLICE] <= rs1_zero ? {SLICE{1'b0}} : rs1_slice;
      rs2_r[phase*SLICE +: SLICE] <= rs2_zero ? {SLICE{1'b0}} : rs2_slice;
    end
  end

  assign rs1_dat = rs1_r;
  assign rs2_dat = rs2_r;

endmodule

// File: rtl/regfile_sequencer.sv
// Sequencer for the phase-multiplexed TinyRV register file.
// Accepts one request on bus (slave modport), walks rf_phase over all slices
// to assemble rs1/rs2, optionally serialises the write-back word into rd one
// slice per cycle, then holds the operands on the response until rsp_ready.
// Ports: clk, rst_n (async, active-low); bus (request/response handshake);
// rf_phase, rf_rs1, rf_rs2, rf_rd, rf_we, rf_wdat to register_file;
// rf_rs1_dat, rf_rs2_dat combinational read slices back from register_file.
module regfile_sequencer
  import regfile_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  regfile_sequencer_if.slave bus,
  output logic [PH_W-1:0]    rf_phase,
  output logic [REG_AW-1:0]  rf_rs1,
  output logic [REG_AW-1:0]  rf_rs2,
  output logic [REG_AW-1:0]  rf_rd,
  output logic               rf_we,
  output logic [SLICE-1:0]   rf_wdat,
  input  logic [SLICE-1:0]   rf_rs1_dat,
  input  logic [SLICE-1:0]   rf_rs2_dat
);

  seq_state_e        state_r, state_s;
  logic [PH_W-1:0]   phase_r, phase_s;
  logic              accept_s;
  logic [REG_AW-1:0] rs1_r, rs2_r, rd_r;
  logic              wr_r;
  logic [XLEN-1:0]   wdata_r;

  // Next-state and phase counter; phase wraps to zero exactly on leaving READ/WRITE.
  always_comb begin
    state_s  = state_r;
    phase_s  = phase_r;
    accept_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_s  = ST_READ;
          phase_s  = PH_ZERO;
          accept_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ: begin
        phase_s = phase_r + PH_ONE;
        if (phase_r == PH_LAST) begin
          // A write to x0 is dropped entirely, so it costs no extra cycles.
          if (wr_r && (rd_r != {REG_AW{1'b0}})) begin
            state_s = ST_WRITE;
          end else begin
            state_s = ST_RESP;
          end
        end else begin
          state_s = ST_READ;
        end
      end
      ST_WRITE: begin
        phase_s = phase_r + PH_ONE;
        if (phase_r == PH_LAST) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_WRITE;
        end
      end
      ST_RESP: begin
        phase_s = PH_ZERO;
        if (bus.rsp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
        phase_s = PH_ZERO;
      end
    endcase
  end

  // State, phase and latched request fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      phase_r <= PH_ZERO;
      rs1_r   <= {REG_AW{1'b0}};
      rs2_r   <= {REG_AW{1'b0}};
      rd_r    <= {REG_AW{1'b0}};
      wr_r    <= 1'b0;
      wdata_r <= {XLEN{1'b0}};
    end else begin
      state_r <= state_s;
      phase_r <= phase_s;
      if (accept_s) begin
        rs1_r   <= bus.req_rs1;
        rs2_r   <= bus.req_rs2;
        rd_r    <= bus.req_rd;
        wr_r    <= bus.req_wr;
        wdata_r <= bus.req_wdata;
      end
    end
  end

  regfile_sequencer_capture u_capture (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (state_r == ST_READ),
    .phase     (phase_r),
    .rs1_zero  (rs1_r == {REG_AW{1'b0}}),
    .rs2_zero  (rs2_r == {REG_AW{1'b0}}),
    .rs1_slice (rf_rs1_dat),
    .rs2_slice (rf_rs2_dat),
    .rs1_dat   (bus.rsp_rs1_dat),
    .rs2_dat   (bus.rsp_rs2_dat)
  );

  // Outputs are pure decodes of flops, so they drop together with an async reset.
  assign bus.req_ready = (state_r == ST_IDLE);
  assign bus.rsp_valid = (state_r == ST_RESP);
  assign rf_phase      = phase_r;
  assign rf_rs1        = rs1_r;
  assign rf_rs2        = rs2_r;
  assign rf_rd         = rd_r;
  assign rf_we         = (state_r == ST_WRITE);
  assign rf_wdat       = rf_we ? slice_of(wdata_r, phase_r) : {SLICE{1'b0}};

endmodule

// File: tb/tb_regfile_sequencer.sv
module tb_regfile_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] rf_phase;
  logic [3:0] rf_rs1, rf_rs2, rf_rd;
  logic       rf_we;
  logic [7:0] rf_wdat, rf_rs1_dat, rf_rs2_dat;

  regfile_sequencer_if bus ();

  regfile_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .rf_phase   (rf_phase),
    .rf_rs1     (rf_rs1),
    .rf_rs2     (rf_rs2),
    .rf_rd      (rf_rd),
    .rf_we      (rf_we),
    .rf_wdat    (rf_wdat),
    .rf_rs1_dat (rf_rs1_dat),
    .rf_rs2_dat (rf_rs2_dat)
  );

  always #5 clk = ~clk;

  // Physical register file: byte slices read combinationally, written on rf_we.
  logic [31:0] rf_mem [16];
  assign rf_rs1_dat = 8'(rf_mem[rf_rs1] >> {rf_phase, 3'b000});
  assign rf_rs2_dat = 8'(rf_mem[rf_rs2] >> {rf_phase, 3'b000});
  always @(posedge clk) begin
    if (rf_we) rf_mem[rf_rd][{rf_phase, 3'b000} +: 8] <= rf_wdat;
  end

  int we_cnt = 0;
  always @(posedge clk) begin
    if (rf_we) we_cnt <= we_cnt + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Architectural model: what each register holds after every completed request.
  logic [31:0] ref_regs [16];

  // Transaction scoreboard: expectations fixed at accept time from the model.
  bit          busy = 1'b0;
  int          k, m_lat;
  logic [3:0]  m_rs1, m_rs2, m_rd;
  logic [31:0] m_wd, m_e1, m_e2;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy = 1'b0;
    end else if (busy) begin
      k = k + 1;
      if (k <= m_lat) begin
        chk("phase_seq", 32'(rf_phase), 32'((k - 1) % 4));
        chk("we_window", 32'(rf_we), 32'(k > 4));
        if (k > 4) chk("wdat", 32'(rf_wdat), (m_wd >> ((k - 5) * 8)) & 32'h0000_00FF);
        chk("busy_ready", 32'(bus.req_ready), 32'd0);
        chk("busy_rspv", 32'(bus.rsp_valid), 32'd0);
        chk("rf_idx", 32'({rf_rs1, rf_rs2, rf_rd}), 32'({m_rs1, m_rs2, m_rd}));
      end else begin
        chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rsp_rs1", bus.rsp_rs1_dat, m_e1);
        chk("rsp_rs2", bus.rsp_rs2_dat, m_e2);
        chk("resp_we", 32'(rf_we), 32'd0);
        chk("resp_phase", 32'(rf_phase), 32'd0);
        chk("resp_ready", 32'(bus.req_ready), 32'd0);
        if (bus.rsp_ready) busy = 1'b0;
      end
    end else begin
      chk("idle_ready", 32'(bus.req_ready), 32'd1);
      chk("idle_rspv", 32'(bus.rsp_valid), 32'd0);
      chk("idle_we", 32'(rf_we), 32'd0);
      chk("idle_phase", 32'(rf_phase), 32'd0);
      if (bus.req_valid && bus.req_ready) begin
        m_rs1 = bus.req_rs1; m_rs2 = bus.req_rs2; m_rd = bus.req_rd; m_wd = bus.req_wdata;
        m_e1  = (m_rs1 == 4'd0) ? 32'd0 : ref_regs[m_rs1];
        m_e2  = (m_rs2 == 4'd0) ? 32'd0 : ref_regs[m_rs2];
        m_lat = (bus.req_wr && m_rd != 4'd0) ? 8 : 4;
        if (bus.req_wr && m_rd != 4'd0) ref_regs[m_rd] = m_wd;
        k    = 0;
        busy = 1'b1;
      end
    end
  end

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                      input logic w, input logic [31:0] wd);
    int n;
    @(posedge clk); #2;
    bus.req_rs1 = a; bus.req_rs2 = b; bus.req_rd = d; bus.req_wr = w; bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 200) begin @(posedge clk); #2; n++; end
    if (n >= 200) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #2;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < 50) begin @(posedge clk); #2; lat++; end
  endtask

  task automatic release_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #2;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    int lat, w0;
    logic [31:0] h1, h2;
    logic [3:0] ra, rb, rd;
    logic rw;
    logic [31:0] rwd;

    bus.req_valid = 1'b0; bus.req_rs1 = 4'd0; bus.req_rs2 = 4'd0; bus.req_rd = 4'd0;
    bus.req_wr = 1'b0; bus.req_wdata = 32'd0; bus.rsp_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rf_mem[i]   <= 32'h0101_0101 * i;
      ref_regs[i] = 32'h0101_0101 * i;
    end
    rf_mem[0]  <= 32'hBADB_AD00;
    rf_mem[3]  <= 32'h1122_3344; ref_regs[3] = 32'h1122_3344;
    rf_mem[5]  <= 32'hA0B0_C0D0; ref_regs[5] = 32'hA0B0_C0D0;
    rf_mem[7]  <= 32'h0000_0001; ref_regs[7] = 32'h0000_0001;
    rf_mem[9]  <= 32'h1234_5678; ref_regs[9] = 32'h1234_5678;

    // Reset state
    #3;
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rspv", 32'(bus.rsp_valid), 32'd0);
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_phase", 32'(rf_phase), 32'd0);
    chk("rst_ops", bus.rsp_rs1_dat | bus.rsp_rs2_dat, 32'd0);
    chk("rst_idx", 32'({rf_rs1, rf_rs2, rf_rd}), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // 1: plain read
    w0 = we_cnt;
    send(4'd3, 4'd5, 4'd0, 1'b0, 32'd0);
    wait_rsp(lat);
    chk("t1_lat", 32'(lat), 32'd4);
    chk("t1_rs1", bus.rsp_rs1_dat, 32'h1122_3344);
    chk("t1_rs2", bus.rsp_rs2_dat, 32'hA0B0_C0D0);
    chk("t1_no_we", 32'(we_cnt - w0), 32'd0);
    release_rsp();

    // 2: read-before-write on the same register
    w0 = we_cnt;
    send(4'd7, 4'd7, 4'd7, 1'b1, 32'hDEAD_BEEF);
    wait_rsp(lat);
    chk("t2_lat", 32'(lat), 32'd8);
    chk("t2_rs1_old", bus.rsp_rs1_dat, 32'h0000_0001);
    chk("t2_rs2_old", bus.rsp_rs2_dat, 32'h0000_0001);
    chk("t2_we_pulses", 32'(we_cnt - w0), 32'd4);
    release_rsp();
    send(4'd7, 4'd0, 4'd0, 1'b0, 32'd0);
    wait_rsp(lat);
    chk("t2_x7_new", bus.rsp_rs1_dat, 32'hDEAD_BEEF);
    chk("t2_x0_rs2", bus.rsp_rs2_dat, 32'd0);
    release_rsp();

    // 3: write to x0 suppressed, x0 read forced to zero
    w0 = we_cnt;
    send(4'd0, 4'd5, 4'd0, 1'b1, 32'hFFFF_FFFF);
    wait_rsp(lat);
    chk("t3_lat", 32'(lat), 32'd4);
    chk("t3_rs1_zero", bus.rsp_rs1_dat, 32'd0);
    chk("t3_rs2", bus.rsp_rs2_dat, 32'hA0B0_C0D0);
    chk("t3_no_we", 32'(we_cnt - w0), 32'd0);
    chk("t3_x0_file", rf_mem[0], 32'hBADB_AD00);
    release_rsp();

    // 4: response back-pressure with a competing request held
    send(4'd3, 4'd5, 4'd0, 1'b0, 32'd0);
    wait_rsp(lat);
    h1 = bus.rsp_rs1_dat; h2 = bus.rsp_rs2_dat;
    bus.req_rs1 = 4'd7; bus.req_rs2 = 4'd3; bus.req_rd = 4'd0; bus.req_wr = 1'b0;
    bus.req_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #2;
      chk("t4_hold_v", 32'(bus.rsp_valid), 32'd1);
      chk("t4_hold_d", bus.rsp_rs1_dat ^ h1 ^ bus.rsp_rs2_dat ^ h2, 32'd0);
      chk("t4_hold_rdy", 32'(bus.req_ready), 32'd0);
    end
    release_rsp();
    chk("t4_idle_rdy", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #2;
    bus.req_valid = 1'b0;
    chk("t4_accepted", 32'(bus.req_ready), 32'd0);
    wait_rsp(lat);
    chk("t4_rs1", bus.rsp_rs1_dat, 32'hDEAD_BEEF);
    chk("t4_rs2", bus.rsp_rs2_dat, 32'h1122_3344);
    release_rsp();

    // 5: reset during WRITE phase 2 leaves a partial write
    send(4'd9, 4'd9, 4'd9, 1'b1, 32'hCAFE_F00D);
    repeat (6) begin @(posedge clk); #2; end
    chk("t5_phase2", 32'(rf_phase), 32'd2);
    chk("t5_we", 32'(rf_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_rspv", 32'(bus.rsp_valid), 32'd0);
    chk("t5_rst_we", 32'(rf_we), 32'd0);
    chk("t5_rst_phase", 32'(rf_phase), 32'd0);
    chk("t5_rst_ready", 32'(bus.req_ready), 32'd1);
    chk("t5_rst_ops", bus.rsp_rs1_dat | bus.rsp_rs2_dat, 32'd0);
    @(posedge clk); #1;
    chk("t5_partial", rf_mem[9], 32'h1234_F00D);
    ref_regs[9] = 32'h1234_F00D;
    @(posedge clk); #2;
    rst_n = 1'b1;
    send(4'd9, 4'd5, 4'd0, 1'b0, 32'd0);
    wait_rsp(lat);
    chk("t5_readback", bus.rsp_rs1_dat, 32'h1234_F00D);
    release_rsp();

    // 6: random requests against the model
    for (int r = 0; r < 20; r++) begin
      ra = 4'($urandom_range(0, 15)); rb = 4'($urandom_range(0, 15));
      rd = 4'($urandom_range(0, 15)); rw = 1'($urandom_range(0, 1)); rwd = $urandom;
      send(ra, rb, rd, rw, rwd);
      wait_rsp(lat);
      chk("t6_lat", 32'(lat), (rw && rd != 4'd0) ? 32'd8 : 32'd4);
      release_rsp();
    end

    repeat (3) @(posedge clk);
    #2;
    chk("final_idle", 32'(busy), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
